// File: rtl/mdr_mem_unit.sv
// Memory Data Register with a request/acknowledge sequencer toward external memory.
// MDR loads from the bus or from memory, writes itself to memory, and aborts on ack timeout.
module mdr_mem_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MDRin,
    input  logic [DATA_W-1:0] MAR_q,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] BusMuxIn_MDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

    logic [1:0]        state_r;
    logic [DATA_W-1:0] mdr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        cnt_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [7:0]        cnt_inc_s;
    logic              timeout_s;
    logic              unused_mar_s;

    assign unused_mar_s = &{1'b0, MAR_q[DATA_W-1:ADDR_W]};

    // Saturating wait counter increment and timeout detection for the current wait cycle.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r != 8'hFF) begin
            cnt_inc_s = cnt_r + 8'd1;
        end else begin
            cnt_inc_s = cnt_r;
        end
        timeout_s = (cnt_inc_s >= TIMEOUT_C);
    end

    // Sequencer state, MDR and all registered handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            mdr_r    <= '0;
            addr_r   <= '0;
            cnt_r    <= 8'd0;
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_read) begin
                        addr_r   <= MAR_q[ADDR_W-1:0];
                        err_r    <= 1'b0;
                        cnt_r    <= 8'd0;
                        mem_rd_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RD_WAIT;
                    end else if (mem_write) begin
                        addr_r   <= MAR_q[ADDR_W-1:0];
                        err_r    <= 1'b0;
                        cnt_r    <= 8'd0;
                        mem_wr_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ST_WR_WAIT;
                        // A same-edge bus load is what gets written.
                        if (MDRin) begin
                            mdr_r <= BusMuxOut;
                        end
                    end else if (MDRin) begin
                        mdr_r <= BusMuxOut;
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (mem_ack) begin
                        if (state_r == ST_RD_WAIT) begin
                            mdr_r <= mem_rdata;
                        end
                        mem_rd_r <= 1'b0;
                        mem_wr_r <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                        if (timeout_s) begin
                            mem_rd_r <= 1'b0;
                            mem_wr_r <= 1'b0;
                            busy_r   <= 1'b0;
                            err_r    <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign BusMuxIn_MDR = mdr_r;
    assign mem_wdata    = mdr_r;
    assign mem_addr     = addr_r;
    assign mem_rd       = mem_rd_r;
    assign mem_wr       = mem_wr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Directed bench for mdr_mem_unit: bus loads, read/write handshakes, timeout and clear.
module tb_mdr_mem_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] BusMuxOut;
    logic        MDRin;
    logic [31:0] MAR_q;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] BusMuxIn_MDR;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int n_rd;
    int n_done;
    int n_both;

    mdr_mem_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MDRin(MDRin), .MAR_q(MAR_q),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .BusMuxIn_MDR(BusMuxIn_MDR), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 1'b1; BusMuxOut = 32'd0; MDRin = 1'b0; MAR_q = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_rdata = 32'd0; mem_ack = 1'b0;
        tick(); tick();
        clr = 1'b0;
        check("rst_mdr", BusMuxIn_MDR, 32'd0);
        check("rst_addr", {23'd0, mem_addr}, 32'd0);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_rd", mem_rd, 1'b0);
        checkb("rst_wr", mem_wr, 1'b0);
        checkb("rst_done", done, 1'b0);
        checkb("rst_err", err, 1'b0);

        // Bus load in IDLE
        MDRin = 1'b1; BusMuxOut = 32'hDEADBEEF;
        tick();
        MDRin = 1'b0;
        check("busload_mdr", BusMuxIn_MDR, 32'hDEADBEEF);
        checkb("busload_busy", busy, 1'b0);

        // Clear in the middle of a read
        MDRin = 1'b1; BusMuxOut = 32'h00001234;
        tick();
        MDRin = 1'b0;
        check("pre_clr_mdr", BusMuxIn_MDR, 32'h00001234);
        mem_read = 1'b1; MAR_q = 32'h00000055;
        tick();
        mem_read = 1'b0;
        checkb("clr_rd_started", mem_rd, 1'b1);
        checkb("clr_busy_started", busy, 1'b1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_mdr", BusMuxIn_MDR, 32'd0);
        checkb("clr_busy", busy, 1'b0);
        checkb("clr_rd", mem_rd, 1'b0);
        checkb("clr_done", done, 1'b0);
        checkb("clr_err", err, 1'b0);
        tick();
        checkb("clr_no_done_later", done, 1'b0);

        // Read with three wait states
        mem_read = 1'b1; MAR_q = 32'hFFFFE1A5;
        tick();
        mem_read = 1'b0;
        n_rd = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_rd) n_rd++;
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h000000FF;
        if (mem_rd) n_rd++;
        check("rd_addr", {23'd0, mem_addr}, 32'h000001A5);
        checkb("rd_no_early_done", done, 1'b0);
        tick();
        mem_ack = 1'b0;
        check("rd_rd_cycles", 32'(n_rd), 32'd4);
        checkb("rd_rd_drop", mem_rd, 1'b0);
        check("rd_mdr", BusMuxIn_MDR, 32'h000000FF);
        checkb("rd_done", done, 1'b1);
        checkb("rd_err", err, 1'b0);
        checkb("rd_busy", busy, 1'b0);
        tick();
        checkb("rd_done_single", done, 1'b0);

        // Bus load plus write in the same cycle, zero-wait ack
        MDRin = 1'b1; mem_write = 1'b1; BusMuxOut = 32'hCAFEF00D; MAR_q = 32'h00000003;
        tick();
        MDRin = 1'b0; mem_write = 1'b0; BusMuxOut = 32'h11111111;
        checkb("wr_wr", mem_wr, 1'b1);
        check("wr_wdata", mem_wdata, 32'hCAFEF00D);
        check("wr_addr", {23'd0, mem_addr}, 32'h00000003);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        checkb("wr_done", done, 1'b1);
        checkb("wr_wr_drop", mem_wr, 1'b0);
        tick();
        check("wr_mdr_after", BusMuxIn_MDR, 32'hCAFEF00D);
        checkb("wr_done_single", done, 1'b0);

        // Read with no ack: timeout after 15 request cycles
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        n_rd = 0; n_done = 0; n_both = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd) n_rd++;
            if (done) n_done++;
            if (done && err) n_both++;
            tick();
        end
        check("to_rd_cycles", 32'(n_rd), 32'd15);
        check("to_no_done", 32'(n_done), 32'd0);
        check("to_done_err_overlap", 32'(n_both), 32'd0);
        checkb("to_err", err, 1'b1);
        checkb("to_busy", busy, 1'b0);
        check("to_mdr", BusMuxIn_MDR, 32'hCAFEF00D);
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        checkb("to_err_cleared", err, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0;
        checkb("to_next_done", done, 1'b1);
        check("to_next_mdr", BusMuxIn_MDR, 32'h0BADF00D);

        // Both strobes together, then a write attempt while busy
        mem_read = 1'b1; mem_write = 1'b1; MAR_q = 32'h000000F0;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        checkb("both_rd", mem_rd, 1'b1);
        checkb("both_wr", mem_wr, 1'b0);
        mem_write = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h00000077;
        tick();
        mem_write = 1'b0; MDRin = 1'b0;
        checkb("busy_wr_ignored", mem_wr, 1'b0);
        check("busy_mdr_frozen", BusMuxIn_MDR, 32'h0BADF00D);
        mem_ack = 1'b1; mem_rdata = 32'h00002222;
        tick();
        mem_ack = 1'b0;
        check("both_mdr", BusMuxIn_MDR, 32'h00002222);
        checkb("both_done", done, 1'b1);
        tick();
        checkb("both_no_wr_after", mem_wr, 1'b0);
        checkb("both_idle", busy, 1'b0);

        // Ack while idle has no effect
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_mdr", BusMuxIn_MDR, 32'h00002222);
        checkb("idle_ack_done", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
